// File: rtl/dffram_ctrl_pkg.sv
// Shared types and constants for the DFFRAM host controller.
//   ctrl_state_e : controller mode (boot LOAD, host RUN)
//   DFFRAM_AW    : default RAM word-address width
//   BE_FULL      : full-word byte write mask
package dffram_ctrl_pkg;
  typedef enum logic {LOAD, RUN} ctrl_state_e;
  localparam int         DFFRAM_AW = 12;
  localparam logic [3:0] BE_FULL   = 4'hF;
endpackage

// File: rtl/dffram_boot_loader.sv
// Boot byte-stream assembler. Packs little-endian bytes into 32-bit words and
// emits a one-cycle write strobe on every 4th byte.
//   CLK, RST            : clock, synchronous active-high reset
//   en                  : loader active (controller in LOAD, not in reset)
//   ld_valid_i/data/skip: boot byte stream and abort request
//   wr_stb/addr/data    : combinational word-write strobe to the RAM mux
//   done                : last word written or skip seen; leave LOAD next edge
module dffram_boot_loader #(
  parameter int AW         = 12,
  parameter int LOAD_WORDS = 4096
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          en,
  input  logic          ld_valid_i,
  input  logic [7:0]    ld_data_i,
  input  logic          ld_skip_i,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          done
);
  localparam logic [AW-1:0] LAST_WORD = AW'(LOAD_WORDS - 1);

  logic [23:0]   asm_q;
  logic [1:0]    byte_cnt;
  logic [AW-1:0] word_cnt;
  logic          take;

  assign take    = en && ld_valid_i;
  assign wr_stb  = take && (byte_cnt == 2'd3);
  assign wr_addr = wr_stb ? word_cnt : '0;
  // The 4th byte goes straight onto the bus; only three are ever buffered.
  assign wr_data = wr_stb ? {ld_data_i, asm_q} : '0;
  assign done    = en && (ld_skip_i || (wr_stb && (word_cnt == LAST_WORD)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      asm_q    <= '0;
      byte_cnt <= '0;
      word_cnt <= '0;
    end else if (en) begin
      if (take) begin
        asm_q    <= {ld_data_i, asm_q[23:8]};
        byte_cnt <= byte_cnt + 2'd1;
        if (wr_stb) word_cnt <= word_cnt + 1'b1;
      end
      // Skip drops any partial word; a coincident 4th byte was already written.
      if (ld_skip_i) begin
        asm_q    <= '0;
        byte_cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/dffram_host_ctrl.sv
// DFFRAM initiator: boot loader in LOAD, Ibex-style req/gnt/rvalid host port
// in RUN. Drives the RAM's EN/WE/DI/A port and aligns responses with the
// RAM's one-cycle registered DO.
//   CLK, RST              : clock, synchronous active-high reset
//   ld_*                  : boot byte stream (ready only in LOAD)
//   boot_done_o           : high in RUN
//   data_*                : host request/response port
//   ram_en/we/di/a, ram_do: DFFRAM port
module dffram_host_ctrl
  import dffram_ctrl_pkg::*;
#(
  parameter int AW         = DFFRAM_AW,
  parameter int LOAD_WORDS = 4096,
  parameter bit BOOT_EN    = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ld_valid_i,
  input  logic [7:0]    ld_data_i,
  input  logic          ld_skip_i,
  output logic          ld_ready_o,
  output logic          boot_done_o,
  input  logic          data_req_i,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [31:0]   data_addr_i,
  input  logic [31:0]   data_wdata_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  output logic [31:0]   data_rdata_o,
  output logic          data_err_o,
  output logic          ram_en_o,
  output logic [3:0]    ram_we_o,
  output logic [31:0]   ram_di_o,
  output logic [AW-1:0] ram_a_o,
  input  logic [31:0]   ram_do_i
);
  localparam ctrl_state_e INIT_STATE = BOOT_EN ? LOAD : RUN;

  ctrl_state_e   state_q, state_d;
  logic          ld_en, ld_stb, ld_done;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          in_range, host_en;
  logic          rvld_q, err_q, rd_q;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^data_addr_i[1:0];

  // Every externally visible strobe is held low during reset.
  assign ld_en       = (state_q == LOAD) && !RST;
  assign ld_ready_o  = ld_en;
  assign boot_done_o = (state_q == RUN);

  dffram_boot_loader #(.AW(AW), .LOAD_WORDS(LOAD_WORDS)) u_loader (
    .CLK        (CLK),
    .RST        (RST),
    .en         (ld_en),
    .ld_valid_i (ld_valid_i),
    .ld_data_i  (ld_data_i),
    .ld_skip_i  (ld_skip_i),
    .wr_stb     (ld_stb),
    .wr_addr    (ld_addr),
    .wr_data    (ld_data),
    .done       (ld_done)
  );

  assign in_range   = ((data_addr_i >> (AW + 2)) == 32'd0);
  assign data_gnt_o = (state_q == RUN) && data_req_i && !RST;
  assign host_en    = data_gnt_o && in_range;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= INIT_STATE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ram_en_o = 1'b0;
    ram_we_o = 4'h0;
    ram_di_o = '0;
    ram_a_o  = '0;
    if (ld_done) state_d = RUN;
    // Loader and host are mutually exclusive by state, so order is arbitrary.
    if (ld_stb) begin
      ram_en_o = 1'b1;
      ram_we_o = BE_FULL;
      ram_di_o = ld_data;
      ram_a_o  = ld_addr;
    end else if (host_en) begin
      ram_en_o = 1'b1;
      ram_we_o = data_we_i ? data_be_i : 4'h0;
      ram_di_o = data_wdata_i;
      ram_a_o  = data_addr_i[AW+1:2];
    end
  end

  // Response stage lines up with the RAM's registered DO.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rvld_q <= 1'b0;
      err_q  <= 1'b0;
      rd_q   <= 1'b0;
    end else begin
      rvld_q <= data_gnt_o;
      err_q  <= data_gnt_o && !in_range;
      rd_q   <= host_en && !data_we_i;
    end
  end

  assign data_rvalid_o = rvld_q && !RST;
  assign data_err_o    = err_q && !RST;
  assign data_rdata_o  = (rd_q && !RST) ? ram_do_i : 32'd0;
endmodule

// File: tb/tb_dffram_host_ctrl.sv
module tb_dffram_host_ctrl;
  localparam int AW = 12;
  localparam int LW = 2;

  logic          CLK = 1'b0, RST = 1'b1;
  logic          ld_valid_i = 0, ld_skip_i = 0;
  logic [7:0]    ld_data_i = 0;
  logic          ld_ready_o, boot_done_o;
  logic          data_req_i = 0, data_we_i = 0;
  logic [3:0]    data_be_i = 0;
  logic [31:0]   data_addr_i = 0, data_wdata_i = 0;
  logic          data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0]   data_rdata_o;
  logic          ram_en_o;
  logic [3:0]    ram_we_o;
  logic [31:0]   ram_di_o, ram_do_i;
  logic [AW-1:0] ram_a_o;

  always #5 CLK = ~CLK;

  dffram_host_ctrl #(.AW(AW), .LOAD_WORDS(LW), .BOOT_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i), .ld_skip_i(ld_skip_i),
    .ld_ready_o(ld_ready_o), .boot_done_o(boot_done_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_di_o(ram_di_o),
    .ram_a_o(ram_a_o), .ram_do_i(ram_do_i)
  );

  // DFFRAM stand-in: registered read, byte-masked write.
  logic [31:0] ram [0:4095];
  logic [31:0] ram_nxt;
  always @(posedge CLK) begin
    if (ram_en_o) begin
      ram_do_i <= ram[ram_a_o];
      ram_nxt = ram[ram_a_o];
      for (int b = 0; b < 4; b++)
        if (ram_we_o[b]) ram_nxt[8*b +: 8] = ram_di_o[8*b +: 8];
      ram[ram_a_o] <= ram_nxt;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:4095];
  bit          exp_v, exp_err, in_load;
  logic [31:0] exp_rd;
  int          word;
  logic [7:0]  bq[$];
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = 0;
    for (int b = 0; b < 4; b++) r += (be[b] ? (nw >> (8*b)) & 32'hFF : (old >> (8*b)) & 32'hFF) << (8*b);
    return r;
  endfunction

  task automatic check_rsp();
    chk("rvalid", {31'd0, data_rvalid_o}, {31'd0, exp_v});
    chk("err", {31'd0, data_err_o}, {31'd0, exp_v && exp_err});
    chk("rdata", data_rdata_o, exp_v ? exp_rd : 32'd0);
    exp_v = 0; exp_err = 0; exp_rd = 0;
  endtask

  task automatic idle_drive();
    ld_valid_i = 0; ld_skip_i = 0; ld_data_i = 0;
    data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
  endtask

  task automatic host(input bit req, input bit we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata);
    int idx;
    bit oor;
    @(posedge CLK); #1;
    idle_drive();
    data_req_i = req; data_we_i = we; data_be_i = be; data_addr_i = addr; data_wdata_i = wdata;
    #3;
    check_rsp();
    chk("boot_done", {31'd0, boot_done_o}, {31'd0, !in_load});
    chk("ld_ready", {31'd0, ld_ready_o}, {31'd0, in_load});
    chk("gnt", {31'd0, data_gnt_o}, {31'd0, req && !in_load});
    oor = (addr / 32'h4000) != 0;
    idx = (addr % 32'h4000) / 4;
    if (req && !in_load) begin
      exp_v = 1; exp_err = oor;
      if (!oor) begin
        chk("ram_en", {31'd0, ram_en_o}, 32'd1);
        chk("ram_a", {20'd0, ram_a_o}, idx);
        chk("ram_we", {28'd0, ram_we_o}, we ? {28'd0, be} : 32'd0);
        if (we) ref_mem[idx] = merge(ref_mem[idx], wdata, be);
        else    exp_rd = ref_mem[idx];
      end else begin
        chk("ram_en_oor", {31'd0, ram_en_o}, 32'd0);
      end
    end else begin
      chk("ram_en_idle", {31'd0, ram_en_o}, 32'd0);
    end
  endtask

  task automatic ld(input bit valid, input logic [7:0] d, input bit skip, input bit req);
    bit nxt;
    @(posedge CLK); #1;
    idle_drive();
    ld_valid_i = valid; ld_data_i = d; ld_skip_i = skip;
    data_req_i = req; data_addr_i = 32'h8;
    #3;
    check_rsp();
    chk("ld_boot_done", {31'd0, boot_done_o}, 32'd0);
    chk("ld_ready", {31'd0, ld_ready_o}, 32'd1);
    chk("ld_gnt", {31'd0, data_gnt_o}, 32'd0);
    nxt = in_load;
    if (valid && bq.size() == 3) begin
      chk("ld_en", {31'd0, ram_en_o}, 32'd1);
      chk("ld_we", {28'd0, ram_we_o}, 32'hF);
      chk("ld_a", {20'd0, ram_a_o}, word);
      chk("ld_di", ram_di_o, {d, bq[2], bq[1], bq[0]});
      ref_mem[word] = {d, bq[2], bq[1], bq[0]};
      word++;
      bq.delete();
      if (word == LW) nxt = 0;
    end else begin
      chk("ld_noen", {31'd0, ram_en_o}, 32'd0);
      if (valid) bq.push_back(d);
    end
    if (skip) begin
      bq.delete();
      nxt = 0;
    end
    in_load = nxt;
  endtask

  task automatic do_reset(input int n, input bit req);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      RST = 1; data_req_i = req; ld_valid_i = 1; ld_data_i = 8'h5A;
      #3;
      chk("rst_rvalid", {31'd0, data_rvalid_o}, 32'd0);
      chk("rst_rdata", data_rdata_o, 32'd0);
      chk("rst_gnt", {31'd0, data_gnt_o}, 32'd0);
      chk("rst_ram", {ram_en_o, ram_we_o, 27'd0}, 32'd0);
      chk("rst_di", ram_di_o, 32'd0);
      chk("rst_ld_ready", {31'd0, ld_ready_o}, 32'd0);
    end
    @(posedge CLK); #1;
    RST = 0; idle_drive();
    #3;
    exp_v = 0; in_load = 1; word = 0; bq.delete();
    chk("post_rvalid", {31'd0, data_rvalid_o}, 32'd0);
    chk("post_err", {31'd0, data_err_o}, 32'd0);
    chk("post_ram_a", {20'd0, ram_a_o}, 32'd0);
    chk("post_boot_done", {31'd0, boot_done_o}, 32'd0);
    chk("post_ld_ready", {31'd0, ld_ready_o}, 32'd1);
  endtask

  initial begin
    logic [7:0] boot_bytes [8];
    for (int i = 0; i < 4096; i++) begin ram[i] = 0; ref_mem[i] = 0; end
    exp_v = 0; exp_err = 0; exp_rd = 0; in_load = 1; word = 0;
    for (int i = 0; i < 8; i++) boot_bytes[i] = 8'(8'h11 * (i + 1));

    do_reset(2, 1'b1);
    // Boot two words; host requests during LOAD must stall.
    for (int i = 0; i < 8; i++) ld(1'b1, boot_bytes[i], 1'b0, i[0]);
    // First grant in the cycle right after the last boot write.
    host(1, 0, 4'h0, 32'h0, 0);
    host(1, 0, 4'h0, 32'h4, 0);
    // Byte-masked write over a known value.
    host(1, 1, 4'hF, 32'h10, 32'h11223344);
    host(1, 1, 4'b0101, 32'h10, 32'hAABBCCDD);
    host(1, 0, 4'h0, 32'h10, 0);
    host(0, 0, 4'h0, 0, 0);
    // Back-to-back reads.
    host(1, 0, 4'h0, 32'h0, 0);
    host(1, 0, 4'h0, 32'h4, 0);
    host(1, 0, 4'h0, 32'h8, 0);
    // Out-of-range read.
    host(1, 0, 4'h0, 32'h0000_4000, 0);
    host(0, 0, 4'h0, 0, 0);
    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | (32'h4000 << $urandom_range(0, 17));
      host($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)), a, $urandom);
    end
    // Reset while a read response is pending.
    host(1, 0, 4'h0, 32'h10, 0);
    do_reset(1, 1'b1);
    // Reset mid-load after three bytes; then reload.
    ld(1, 8'hC1, 0, 0); ld(1, 8'hC2, 0, 0); ld(1, 8'hC3, 0, 0);
    do_reset(1, 1'b0);
    ld(1, 8'hA1, 0, 0); ld(1, 8'hA2, 0, 0); ld(1, 8'hA3, 0, 0); ld(1, 8'hA4, 0, 1);
    ld(1, 8'hE5, 0, 0); ld(1, 8'hE6, 0, 1);
    ld(0, 8'h00, 1, 0);
    // Partial word 1 must not have reached the RAM.
    host(1, 0, 4'h0, 32'h4, 0);
    host(1, 0, 4'h0, 32'h0, 0);
    host(0, 0, 4'h0, 0, 0);
    chk("ram_word1_kept", ram[1], ref_mem[1]);
    chk("ram_word0_reload", ram[0], ref_mem[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
